bcdbin8: RTL and testbench

BCDBIN8 -- requirements
Module: bcdbin8

---
 rtl/bcdbin8_pkg.sv | 27 ++
 rtl/bcdbin8_sub3.sv | 19 +
 rtl/bcdbin8.sv | 159 +++++++++++++++
 tb/tb_bcdbin8.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcdbin8_pkg.sv
// Shared definitions for the 3-digit BCD to 8-bit binary converter.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the datapath widths and the shift iteration
// count used by bcdbin8 and its correction cell.
package bcdbin8_pkg;

    localparam int BCD_W  = 10;           // 2-bit hundreds + 4-bit tens + 4-bit units
    localparam int BIN_W  = 8;            // visible binary result width
    localparam int RES_W  = BIN_W + 1;    // internal result carries the >255 bit
    localparam int N_ITER = 9;            // one right shift per result bit
    localparam int CNT_W  = 4;            // holds 0..N_ITER
    localparam int WORD_W = BCD_W + RES_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A BCD digit is legal only in 0..9.
    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcdbin8_sub3.sv
// BCD correction cell: nibble >= 8 becomes nibble - 3, otherwise passes through.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   i_nib  nibble taken from the BCD field just after a right shift
//   o_nib  corrected nibble
//
// Undoes the add-3 step of a shift-add-3 encoder: after a right shift a
// digit's former bit 0 of the next-higher digit lands in bit 3 worth 8 here
// but only 5 in decimal, hence the subtract-3.
module bcdbin8_sub3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcdbin8.sv
// Converts a 3-digit BCD value (000..399) to binary by shift-subtract-3.
// Latency: start accepted at edge N; done pulses after edge N+10 (valid) or N+1 (bad digit).
// Backpressure: none; start is ignored unless idle, never queued.
//
// Ports:
//   i_clk       clock, all state on the rising edge
//   i_rst       asynchronous active-high reset
//   i_start     conversion request, sampled only when idle
//   i_hundreds  BCD hundreds digit 0..3
//   i_tens      BCD tens digit, legal 0..9
//   i_units     BCD units digit, legal 0..9
//   o_busy      conversion in progress
//   o_done      one-cycle result strobe
//   o_bin       binary result (value mod 256), held until the next accepted start
//   o_err       a tens or units digit was above 9; result forced to 0
//   o_ovf       value exceeded 255
module bcdbin8
    import bcdbin8_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_hundreds,
    input  logic [3:0]       i_tens,
    input  logic [3:0]       i_units,
    output logic             o_busy,
    output logic             o_done,
    output logic [BIN_W-1:0] o_bin,
    output logic             o_err,
    output logic             o_ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [RES_W-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inv;
    logic               r_busy;
    logic               r_done;
    logic [BIN_W-1:0]   r_bin;
    logic               r_err;
    logic               r_ovf;

    logic               w_in_bad;
    logic               w_accept;
    logic [WORD_W-1:0]  w_word_sh;
    logic [BCD_W-1:0]   w_bcd_sh;
    logic [RES_W-1:0]   w_res_sh;
    logic [3:0]         w_units_fix;
    logic [3:0]         w_tens_fix;
    logic [BCD_W-1:0]   w_bcd_fix;

    assign w_in_bad = digit_bad(i_tens) || digit_bad(i_units);

    // BCD and result registers shift as one word: the BCD LSB falls into
    // the result MSB, so after N_ITER shifts the whole value sits in r_res.
    assign w_word_sh = {r_bcd, r_res} >> 1;
    assign w_bcd_sh  = w_word_sh[WORD_W-1:RES_W];
    assign w_res_sh  = w_word_sh[RES_W-1:0];

    bcdbin8_sub3 u_sub3_units (
        .i_nib (w_bcd_sh[3:0]),
        .o_nib (w_units_fix)
    );

    bcdbin8_sub3 u_sub3_tens (
        .i_nib (w_bcd_sh[7:4]),
        .o_nib (w_tens_fix)
    );

    // Hundreds is at most 3, so it can never reach 8 and needs no cell.
    assign w_bcd_fix = {w_bcd_sh[9:8], w_tens_fix, w_units_fix};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The done-pulse cycle is the tail of the DONE phase, so a start seen
    // while r_done is high is treated like one seen in DONE and dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_in_bad ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bcd  <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_inv  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_bin  <= '0;
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bcd  <= {i_hundreds, i_tens, i_units};
                        r_res  <= '0;
                        r_inv  <= w_in_bad;
                        r_cnt  <= w_in_bad ? '0 : CNT_W'(N_ITER);
                        r_err  <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_bcd_fix;
                    r_res <= w_res_sh;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_bin  <= r_inv ? '0 : r_res[BIN_W-1:0];
                    r_err  <= r_inv;
                    r_ovf  <= r_inv ? 1'b0 : r_res[BIN_W];
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bin  = r_bin;
    assign o_err  = r_err;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_bcdbin8.sv
module tb_bcdbin8;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [1:0] i_hundreds;
    logic [3:0] i_tens;
    logic [3:0] i_units;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_bin;
    logic       o_err;
    logic       o_ovf;

    bcdbin8 dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_hundreds (i_hundreds),
        .i_tens     (i_tens),
        .i_units    (i_units),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bin      (o_bin),
        .o_err      (o_err),
        .o_ovf      (o_ovf)
    );

    typedef struct {
        logic [7:0] bin;
        logic       err;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) begin
        if (o_done === 1'b1) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference value of a 3-digit BCD input, from plain decimal arithmetic.
    function automatic exp_t model(input int h, input int t, input int u);
        exp_t e;
        int   v;
        if (t > 9 || u > 9) begin
            e.bin = 8'h00; e.err = 1'b1; e.ovf = 1'b0;
        end else begin
            v = h * 100 + t * 10 + u;
            e.bin = v[7:0]; e.err = 1'b0; e.ovf = (v > 255);
        end
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_bin"}, 32'(o_bin), 32'(e.bin));
            chk({tag, "_err"}, 32'(o_err), 32'(e.err));
            chk({tag, "_ovf"}, 32'(o_ovf), 32'(e.ovf));
        end
    endtask

    // Count negedges until o_done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge i_clk);
            cyc++;
            if (o_done === 1'b1 || cyc >= 60) break;
        end
    endtask

    // One start pulse; optional re-pulse with other digits at cycle 4.
    task automatic convert(input string tag, input int h, input int t, input int u,
                           input int lat, input bit repulse);
        int cyc;
        int done_before;
        exp_t e;
        @(negedge i_clk);
        i_hundreds = 2'(h); i_tens = 4'(t); i_units = 4'(u);
        i_start = 1'b1;
        e = model(h, t, u);
        exp_q.push_back(e);
        done_before = n_done;
        cyc = 0;
        while (1) begin
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            if (o_done === 1'b1 || cyc >= 60) break;
            if (repulse && cyc == 4) begin
                i_hundreds = 2'd0; i_tens = 4'd1; i_units = 4'd1;
                i_start = 1'b1;
            end
            if (lat > 2 && cyc == 5) chk({tag, "_busy_mid"}, 32'(o_busy), 32'd1);
        end
        chk({tag, "_done_seen"}, 32'(o_done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        pop_check(tag);
        @(negedge i_clk);
        chk({tag, "_done_pulse1"}, 32'(o_done), 32'd0);
        chk({tag, "_done_count"}, 32'(n_done - done_before), 32'd1);
        chk({tag, "_bin_held"}, 32'(o_bin), 32'(e.bin));
        chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int c1;
        int c2;
        int done_before;
        i_rst = 1'b1; i_start = 1'b0;
        i_hundreds = '0; i_tens = '0; i_units = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_bin",  32'(o_bin),  32'd0);
        chk("rst_err",  32'(o_err),  32'd0);
        chk("rst_ovf",  32'(o_ovf),  32'd0);
        i_rst = 1'b0;

        convert("v255", 2, 5, 5, 11, 1'b0);
        convert("v000", 0, 0, 0, 11, 1'b0);
        convert("v128", 1, 2, 8, 11, 1'b0);
        convert("v099", 0, 9, 9, 11, 1'b0);
        convert("v256", 2, 5, 6, 11, 1'b0);
        convert("v399", 3, 9, 9, 11, 1'b0);
        convert("badt", 0, 10, 3, 2, 1'b0);
        convert("badu", 0, 0, 15, 2, 1'b0);
        convert("v137_rep", 1, 3, 7, 11, 1'b1);

        // start held high: valid back-to-back period
        @(negedge i_clk);
        i_hundreds = 2'd0; i_tens = 4'd4; i_units = 4'd2; i_start = 1'b1;
        exp_q.push_back(model(0, 4, 2));
        exp_q.push_back(model(0, 4, 2));
        wait_done(c1);
        chk("b2b_first_lat", 32'(c1), 32'd11);
        pop_check("b2b_first");
        wait_done(c2);
        i_start = 1'b0;
        chk("b2b_period", 32'(c2), 32'd12);
        pop_check("b2b_second");
        repeat (2) @(negedge i_clk);
        chk("b2b_stopped", 32'(o_busy), 32'd0);

        // start held high: invalid back-to-back period
        @(negedge i_clk);
        i_tens = 4'd10; i_units = 4'd3; i_start = 1'b1;
        exp_q.push_back(model(0, 10, 3));
        exp_q.push_back(model(0, 10, 3));
        wait_done(c1);
        pop_check("b2b_bad_first");
        wait_done(c2);
        i_start = 1'b0;
        chk("b2b_bad_period", 32'(c2), 32'd3);
        pop_check("b2b_bad_second");
        repeat (3) @(negedge i_clk);

        convert("v042", 0, 4, 2, 11, 1'b0);

        // asynchronous reset during SHIFT cycle 5
        @(negedge i_clk);
        i_hundreds = 2'd2; i_tens = 4'd5; i_units = 4'd5; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("abort_busy_before", 32'(o_busy), 32'd1);
        done_before = n_done;
        #2 i_rst = 1'b1;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_bin",  32'(o_bin),  32'd0);
        chk("abort_err",  32'(o_err),  32'd0);
        chk("abort_ovf",  32'(o_ovf),  32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (15) @(negedge i_clk);
        chk("abort_no_done", 32'(n_done - done_before), 32'd0);
        convert("v100", 1, 0, 0, 11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
